// File: rtl/rate_limiter_pkg.sv
// ---------------------------------------------------------------------------
// rate_limiter_pkg
//   Shared widths and types for the slew-rate limiter.
//   DATA_W : width of the target/output value (unsigned)
//   STEP_W : width of the per-cycle step limit (unsigned)
// ---------------------------------------------------------------------------
package rate_limiter_pkg;

   localparam int DATA_W = 6;
   localparam int STEP_W = 3;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [STEP_W-1:0] step_t;

endpackage : rate_limiter_pkg

// File: rtl/rl_next_calc.sv
// ---------------------------------------------------------------------------
// rl_next_calc
//   Combinational next-value logic for the rate limiter. It moves the current
//   output toward the target by at most step_size LSBs, landing exactly on the
//   target when the remaining distance is within one step.
// Ports
//   d_in      : target value (unsigned)
//   d_out     : current registered output (unsigned)
//   step_size : maximum change per cycle (unsigned, 0 = hold)
//   d_next    : value the output register loads on the next edge
// ---------------------------------------------------------------------------
module rl_next_calc
   import rate_limiter_pkg::*;
(
   input  data_t d_in,
   input  data_t d_out,
   input  step_t step_size,
   output data_t d_next
);

   // The distance is formed one bit wider than the data so that the sign bit
   // tells direction and the magnitude never wraps at either rail.
   function automatic data_t slew_clamp(input data_t tgt, input data_t cur, input step_t s);
      logic signed [DATA_W:0] diff;
      logic        [DATA_W:0] mag;
      logic        [DATA_W:0] s_ext;
      logic                   neg;
      data_t                  res;
      diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      neg   = diff[DATA_W];
      mag   = neg ? $unsigned(-diff) : $unsigned(diff);
      s_ext = {{(DATA_W + 1 - STEP_W){1'b0}}, s};
      res   = cur;
      if (mag == '0) begin
         res = cur;
      end else if (mag <= s_ext) begin
         res = tgt;
      end else if (neg) begin
         // mag > s here, so cur - s stays above tgt and cannot go below 0
         res = cur - data_t'(s);
      end else begin
         // mag > s here, so cur + s stays below tgt and cannot exceed the rail
         res = cur + data_t'(s);
      end
      return res;
   endfunction

   assign d_next = slew_clamp(d_in, d_out, step_size);

endmodule : rl_next_calc

// File: rtl/rate_limiter.sv
// ---------------------------------------------------------------------------
// rate_limiter
//   Slew-rate limiter for an unsigned control value. Each rising edge the
//   registered output moves toward d_in by at most step_size LSBs, with no
//   overshoot and no wrap at 0 or full scale. One cycle of latency.
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset, forces d_out to 0
//   d_in      : target value, sampled every rising edge
//   step_size : maximum change of d_out per cycle (0 = hold)
//   d_out     : rate-limited output, driven straight from a register
// ---------------------------------------------------------------------------
module rate_limiter
   import rate_limiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d_in,
   input  logic [STEP_W-1:0] step_size,
   output logic [DATA_W-1:0] d_out
);

   data_t d_out_q;
   data_t d_out_d;
   data_t d_next;

   rl_next_calc u_next_calc (
      .d_in      (d_in),
      .d_out     (d_out_q),
      .step_size (step_size),
      .d_next    (d_next)
   );

   always_comb begin
      d_out_d = d_next;
   end

   // Output register: the only state in the block, so it takes the reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_q <= '0;
      end else begin
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule : rate_limiter

// File: tb/tb_rate_limiter.sv
module tb_rate_limiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] d_in;
   logic [2:0] step_size;
   logic [5:0] d_out;

   int n_cmp = 0;
   int n_bad = 0;

   rate_limiter dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .step_size (step_size),
      .d_out     (d_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Apply inputs, clock one edge, sample 1 time unit later and compare.
   task automatic cycle(input logic r, input logic [5:0] d, input logic [2:0] s,
                        input logic [5:0] exp, input string tag);
      rst       = r;
      d_in      = d;
      step_size = s;
      @(posedge clk);
      #1;
      check(tag, d_out, exp);
   endtask

   int exp_up30[6]   = '{7, 14, 21, 28, 30, 30};
   int exp_dn15[4]   = '{23, 16, 15, 15};
   int exp_dn2[4]    = '{11, 5, 2, 2};
   int exp_up63[11]  = '{9, 16, 23, 30, 37, 44, 51, 58, 63, 63, 63};
   int exp_63to2[10] = '{56, 49, 42, 35, 28, 21, 14, 7, 2, 2};
   int exp_ramp37[5] = '{9, 16, 23, 30, 37};
   int exp_rerun[4]  = '{7, 14, 21, 28};

   initial begin
      rst = 1'b1;
      d_in = '0;
      step_size = '0;
      #2;

      // 1. reset
      cycle(1'b1, 6'd0, 3'd0, 6'd0, "rst_c0");
      cycle(1'b1, 6'd0, 3'd0, 6'd0, "rst_c1");
      cycle(1'b0, 6'd0, 3'd0, 6'd0, "post_rst0");
      cycle(1'b0, 6'd0, 3'd0, 6'd0, "post_rst1");

      // 2. ramp up to 30
      foreach (exp_up30[i])
         cycle(1'b0, 6'd30, 3'd7, 6'(exp_up30[i]), $sformatf("up30_%0d", i));

      // 3. down to 15, then small step up to 17
      foreach (exp_dn15[i])
         cycle(1'b0, 6'd15, 3'd7, 6'(exp_dn15[i]), $sformatf("dn15_%0d", i));
      cycle(1'b0, 6'd17, 3'd7, 6'd17, "to17");
      cycle(1'b0, 6'd17, 3'd7, 6'd17, "hold17");

      // 4. step 0 holds regardless of target
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 6'd10, 3'd0, 6'd17, $sformatf("s0_hold_%0d", i));
      cycle(1'b0, 6'd63, 3'd0, 6'd17, "s0_hold_hi");

      // 5. down to 2 (no underflow), up to 63 (no overflow)
      foreach (exp_dn2[i])
         cycle(1'b0, 6'd2, 3'd6, 6'(exp_dn2[i]), $sformatf("dn2_%0d", i));
      foreach (exp_up63[i])
         cycle(1'b0, 6'd63, 3'd7, 6'(exp_up63[i]), $sformatf("up63_%0d", i));

      // full-scale descent landing exactly on 2
      foreach (exp_63to2[i])
         cycle(1'b0, 6'd2, 3'd7, 6'(exp_63to2[i]), $sformatf("dn63to2_%0d", i));

      // 6. reset mid-ramp at 37 heading to 63, then ramp restarts from 0
      foreach (exp_ramp37[i])
         cycle(1'b0, 6'd63, 3'd7, 6'(exp_ramp37[i]), $sformatf("ramp37_%0d", i));
      cycle(1'b1, 6'd63, 3'd7, 6'd0, "mid_rst");
      foreach (exp_rerun[i])
         cycle(1'b0, 6'd63, 3'd7, 6'(exp_rerun[i]), $sformatf("rerun_%0d", i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_rate_limiter
